// File: rtl/window_gen_3x3.sv
// Raster-to-window front end: turns a row-major pixel stream into 3x3
// neighbourhoods using two line buffers and a 3-column shift register.
module window_gen_3x3 #(
  parameter int DATA_SIZE   = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_valid,
  input  logic                 i_sof,
  input  logic [DATA_SIZE-1:0] i_data,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_window [KERNEL_SIZE][KERNEL_SIZE],
  output logic                 o_frame_done,
  output logic                 o_sof_err
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_reg, cur_col;
  logic [RW-1:0] row_reg, cur_row;
  logic          emit, at_origin, last_pixel;

  logic [DATA_SIZE-1:0] lb0 [IMG_WIDTH];
  logic [DATA_SIZE-1:0] lb1 [IMG_WIDTH];
  logic [DATA_SIZE-1:0] tap [KERNEL_SIZE];
  logic [DATA_SIZE-1:0] sr_reg  [KERNEL_SIZE][KERNEL_SIZE];
  logic [DATA_SIZE-1:0] sr_next [KERNEL_SIZE][KERNEL_SIZE];

  // A start-of-frame pixel is always position (0,0), whatever the counters say.
  assign at_origin  = (col_reg == '0) && (row_reg == '0);
  assign cur_col    = i_sof ? '0 : col_reg;
  assign cur_row    = i_sof ? '0 : row_reg;
  assign emit       = i_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign last_pixel = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  assign tap[0] = lb1[cur_col];
  assign tap[1] = lb0[cur_col];
  assign tap[2] = i_data;

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    assign sr_next[gi][0] = sr_reg[gi][1];
    assign sr_next[gi][1] = sr_reg[gi][2];
    assign sr_next[gi][2] = tap[gi];
  end

  // Line buffers are never reset; windows are suppressed until they hold current-frame rows.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      col_reg      <= '0;
      row_reg      <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_sof_err    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          sr_reg[i][j]   <= '0;
          o_window[i][j] <= '0;
        end
      end
    end else begin
      o_valid      <= emit;
      o_frame_done <= emit && last_pixel;
      o_sof_err    <= i_valid && i_sof && !at_origin;
      if (i_valid) begin
        sr_reg <= sr_next;
        if (emit) begin
          o_window <= sr_next;
        end
        if (cur_col == COL_LAST) begin
          col_reg <= '0;
          row_reg <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          col_reg <= cur_col + CW'(1);
          row_reg <= cur_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: a 4x4 and a 5x3 instance driven with directed and
// random pixel streams, compared against an image-array reference model.
module tb_window_gen_3x3;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic v0, s0, ov0, fd0, se0;
  logic [7:0] d0;
  logic [7:0] w0 [3][3];
  logic v1, s1, ov1, fd1, se1;
  logic [7:0] d1;
  logic [7:0] w1 [3][3];

  window_gen_3x3 #(.DATA_SIZE(8), .KERNEL_SIZE(3), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut0 (
    .i_clk(clk), .i_nrst(nrst), .i_valid(v0), .i_sof(s0), .i_data(d0),
    .o_valid(ov0), .o_window(w0), .o_frame_done(fd0), .o_sof_err(se0)
  );

  window_gen_3x3 #(.DATA_SIZE(8), .KERNEL_SIZE(3), .IMG_WIDTH(5), .IMG_HEIGHT(3)) dut1 (
    .i_clk(clk), .i_nrst(nrst), .i_valid(v1), .i_sof(s1), .i_data(d1),
    .o_valid(ov1), .o_window(w1), .o_frame_done(fd1), .o_sof_err(se1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: image dimensions, current position, received pixels, last window.
  int mw [2];
  int mh [2];
  int mr [2];
  int mc [2];
  logic [7:0] img [2][8][8];
  logic [71:0] last_win [2];
  int nwin [2];
  int ndone [2];

  function automatic logic [71:0] pack(input logic [7:0] w [3][3]);
    logic [71:0] p;
    p = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[(i*3+j)*8 +: 8] = w[i][j];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mr[k] = 0;
      mc[k] = 0;
      last_win[k] = '0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid0"}, 72'(ov0), 72'(0));
    chk({tag, "_done0"},  72'(fd0), 72'(0));
    chk({tag, "_err0"},   72'(se0), 72'(0));
    chk({tag, "_win0"},   pack(w0), 72'(0));
    chk({tag, "_valid1"}, 72'(ov1), 72'(0));
    chk({tag, "_win1"},   pack(w1), 72'(0));
  endtask

  // One clock cycle on instance k; outputs checked 1 time unit after the edge.
  task automatic step(input int k, input bit v, input bit s, input logic [7:0] d);
    bit ev, ed, ee, ov, ofd, ose;
    logic [71:0] ow;
    ev = 0; ed = 0; ee = 0;
    if (k == 0) begin v0 = v; s0 = s; d0 = d; end
    else begin v1 = v; s1 = s; d1 = d; end
    if (v) begin
      if (s) begin
        ee = (mr[k] != 0) || (mc[k] != 0);
        mr[k] = 0;
        mc[k] = 0;
      end
      img[k][mr[k]][mc[k]] = d;
      if (mr[k] >= 2 && mc[k] >= 2) begin
        ev = 1;
        ed = (mr[k] == mh[k] - 1) && (mc[k] == mw[k] - 1);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            last_win[k][(i*3+j)*8 +: 8] = img[k][mr[k]-2+i][mc[k]-2+j];
      end
      mc[k]++;
      if (mc[k] == mw[k]) begin
        mc[k] = 0;
        mr[k]++;
        if (mr[k] == mh[k]) mr[k] = 0;
      end
    end
    @(posedge clk);
    #1;
    if (k == 0) begin ov = ov0; ofd = fd0; ose = se0; ow = pack(w0); v0 = 0; s0 = 0; end
    else begin ov = ov1; ofd = fd1; ose = se1; ow = pack(w1); v1 = 0; s1 = 0; end
    if (ov) nwin[k]++;
    if (ofd) ndone[k]++;
    chk($sformatf("i%0d_valid", k), 72'(ov),  72'(ev));
    chk($sformatf("i%0d_done", k),  72'(ofd), 72'(ed));
    chk($sformatf("i%0d_soferr", k), 72'(ose), 72'(ee));
    chk($sformatf("i%0d_window", k), ow, last_win[k]);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 nrst = 1'b0;
    #1 check_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    model_reset();
  endtask

  int base0, base1, dbase;
  logic [71:0] e;

  initial begin
    v0 = 0; s0 = 0; d0 = 0; v1 = 0; s1 = 0; d1 = 0;
    mw[0] = 4; mh[0] = 4; mw[1] = 5; mh[1] = 3;
    nwin[0] = 0; nwin[1] = 0; ndone[0] = 0; ndone[1] = 0;
    model_reset();
    #12 check_zero("reset");
    @(posedge clk);
    #1 nrst = 1'b1;

    // Basic 4x4 frame, value 4r+c+1.
    base0 = nwin[0]; dbase = ndone[0];
    for (int p = 0; p < 16; p++) step(0, 1, p == 0, 8'(p + 1));
    chk("basic_count", 72'(nwin[0] - base0), 72'(4));
    chk("basic_done_count", 72'(ndone[0] - dbase), 72'(1));
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) e[(i*3+j)*8 +: 8] = 8'(4*(i+1) + (j+1) + 1);
    chk("basic_last_win", pack(w0), e);

    // Gapped input.
    base0 = nwin[0];
    for (int p = 0; p < 16; p++) begin
      step(0, 1, p == 0, 8'(p + 1));
      step(0, 0, 0, 8'hEE);
    end
    chk("gapped_count", 72'(nwin[0] - base0), 72'(4));

    // Back-to-back frames, second one 101..116.
    base0 = nwin[0];
    for (int p = 0; p < 16; p++) step(0, 1, p == 0, 8'(p + 1));
    for (int p = 0; p < 16; p++) step(0, 1, p == 0, 8'(p + 101));
    chk("b2b_count", 72'(nwin[0] - base0), 72'(8));

    // Mid-frame start-of-frame on pixel 7, then a fresh full frame.
    for (int p = 0; p < 6; p++) step(0, 1, p == 0, 8'(p + 1));
    for (int p = 0; p < 16; p++) step(0, 1, p == 0, 8'(p + 201));

    // Reset mid-frame, then a full frame without sof.
    for (int p = 0; p < 10; p++) step(0, 1, p == 0, 8'(p + 1));
    do_reset();
    base0 = nwin[0];
    for (int p = 0; p < 16; p++) step(0, 1, 0, 8'(p + 1));
    chk("post_rst_count", 72'(nwin[0] - base0), 72'(4));
    chk("post_rst_last_win", pack(w0), e);

    // Non-square 5x3 frame; pixel 16 is (0,0), so sof there is silent.
    base1 = nwin[1]; dbase = ndone[1];
    for (int p = 0; p < 15; p++) step(1, 1, p == 0, 8'(p + 1));
    chk("ns_count", 72'(nwin[1] - base1), 72'(3));
    chk("ns_done_count", 72'(ndone[1] - dbase), 72'(1));
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) e[(i*3+j)*8 +: 8] = 8'(5*i + (j+2) + 1);
    chk("ns_last_win", pack(w1), e);
    step(1, 1, 1, 8'd99);

    // Random streams with gaps and occasional sof on both instances.
    for (int n = 0; n < 400; n++)
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, 8'($urandom));
    for (int n = 0; n < 300; n++)
      step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
